// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoder controls, register data, the sign-extended immediate and
// register specifiers for EX. A load in EX whose destination is read by the
// instruction in ID raises stall and loads a bubble. Flush from branch
// resolution also loads a bubble and takes priority over the hazard.
module id_ex_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_reg_dst,
   input  logic             id_reg_write,
   input  logic             id_alu_src,
   input  logic [1:0]       id_alu_op,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_mem_to_reg,
   input  logic             id_branch,
   input  logic [DW-1:0]    id_pc4,
   input  logic [DW-1:0]    id_rs_data,
   input  logic [DW-1:0]    id_rt_data,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic [15:0]      id_imm,
   input  logic             flush,
   output logic             ex_valid,
   output logic             ex_reg_write,
   output logic             ex_alu_src,
   output logic [1:0]       ex_alu_op,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_mem_to_reg,
   output logic             ex_branch,
   output logic [DW-1:0]    ex_pc4,
   output logic [DW-1:0]    ex_rs_data,
   output logic [DW-1:0]    ex_rt_data,
   output logic [DW-1:0]    ex_imm_sext,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_write_reg,
   output logic             stall,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic hazard;
   logic rt_is_source;
   logic bubble_load;

   // Load-use detection: rt only counts as a source for R-type and stores.
   always_comb begin
      rt_is_source = id_reg_dst | id_mem_write;
      hazard = ex_valid & ex_mem_read & (ex_write_reg != 5'd0) & id_valid &
               ((ex_write_reg == id_rs) | (rt_is_source & (ex_write_reg == id_rt)));
   end

   // A squashed ID instruction never needs holding, so flush masks the stall.
   assign stall       = hazard & ~flush;
   assign bubble_load = flush | hazard;

   // Pipeline register: bubble on flush or hazard, otherwise capture ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_alu_op     <= 2'b00;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_branch     <= 1'b0;
         ex_pc4        <= '0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm_sext   <= '0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_write_reg  <= 5'd0;
      end else if (bubble_load) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_alu_op     <= 2'b00;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_branch     <= 1'b0;
         ex_pc4        <= '0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm_sext   <= '0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_write_reg  <= 5'd0;
      end else begin
         // Controls of an invalid slot are forced to 0 so they cannot act in EX.
         ex_valid      <= id_valid;
         ex_reg_write  <= id_valid & id_reg_write;
         ex_alu_src    <= id_valid & id_alu_src;
         ex_alu_op     <= id_valid ? id_alu_op : 2'b00;
         ex_mem_read   <= id_valid & id_mem_read;
         ex_mem_write  <= id_valid & id_mem_write;
         ex_mem_to_reg <= id_valid & id_mem_to_reg;
         ex_branch     <= id_valid & id_branch;
         ex_pc4        <= id_pc4;
         ex_rs_data    <= id_rs_data;
         ex_rt_data    <= id_rt_data;
         ex_imm_sext   <= {{(DW-16){id_imm[15]}}, id_imm};
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_write_reg  <= (id_valid & id_reg_dst) ? id_rd : id_rt;
      end
   end

   // Saturating debug counters; flush has priority so one edge bumps at most one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (flush) begin
         if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (hazard) begin
         if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scenario tasks plus randomized traffic against a
// transaction-level model of the ID/EX register and its hazard rule.
module tb_id_ex_stage;

   localparam int DW    = 32;
   localparam int CNT_W = 8;   // narrow counters so saturation is reachable quickly
   localparam int SAT   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        valid;
      logic        reg_dst;
      logic        reg_write;
      logic        alu_src;
      logic [1:0]  alu_op;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
   } id_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        alu_src;
      logic [1:0]  alu_op;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm_sext;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  write_reg;
   } ex_t;

   localparam int KIND_R = 0, KIND_JZ = 1, KIND_SW = 2, KIND_LW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   id_t  idv = '0;
   logic fl = 1'b0;

   logic             ex_valid, ex_reg_write, ex_alu_src, ex_mem_read;
   logic             ex_mem_write, ex_mem_to_reg, ex_branch, stall;
   logic [1:0]       ex_alu_op;
   logic [DW-1:0]    ex_pc4, ex_rs_data, ex_rt_data, ex_imm_sext;
   logic [4:0]       ex_rs, ex_rt, ex_write_reg;
   logic [CNT_W-1:0] bubble_cnt, flush_cnt;

   id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(idv.valid), .id_reg_dst(idv.reg_dst), .id_reg_write(idv.reg_write),
      .id_alu_src(idv.alu_src), .id_alu_op(idv.alu_op), .id_mem_read(idv.mem_read),
      .id_mem_write(idv.mem_write), .id_mem_to_reg(idv.mem_to_reg), .id_branch(idv.branch),
      .id_pc4(idv.pc4), .id_rs_data(idv.rs_data), .id_rt_data(idv.rt_data),
      .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd), .id_imm(idv.imm),
      .flush(fl),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
      .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
      .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm_sext(ex_imm_sext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
      .stall(stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   ex_t dut_bus;
   assign dut_bus = {ex_valid, ex_reg_write, ex_alu_src, ex_alu_op, ex_mem_read,
                     ex_mem_write, ex_mem_to_reg, ex_branch, ex_pc4, ex_rs_data,
                     ex_rt_data, ex_imm_sext, ex_rs, ex_rt, ex_write_reg};

   // Reference model state: what EX should hold, plus event counts.
   ex_t m = '0;
   int  bcnt = 0;
   int  fcnt = 0;
   int  cmp = 0;
   int  err = 0;

   // The destination of a discarded slot is don't-care, so it is masked out.
   function automatic ex_t ex_mask(input ex_t e);
      ex_t r = e;
      if (!m.valid) r.write_reg = 5'd0;
      return r;
   endfunction

   function automatic id_t mk(input int kind, input int rs, input int rt, input int rd);
      id_t x;
      x.valid   = 1'b1;
      x.pc4     = $urandom;
      x.rs_data = $urandom;
      x.rt_data = $urandom;
      x.imm     = 16'($urandom);
      x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
      x.reg_dst = 0; x.reg_write = 0; x.alu_src = 0; x.alu_op = 2'(kind);
      x.mem_read = 0; x.mem_write = 0; x.mem_to_reg = 0; x.branch = 0;
      case (kind)
         KIND_R:  begin x.reg_dst = 1; x.reg_write = 1; end
         KIND_JZ: x.branch = 1;
         KIND_SW: begin x.alu_src = 1; x.mem_write = 1; end
         default: begin x.reg_write = 1; x.alu_src = 1; x.mem_read = 1; x.mem_to_reg = 1; end
      endcase
      return x;
   endfunction

   // Does the instruction x read the register a load in EX is about to write?
   function automatic bit model_hazard(input id_t x);
      bit rt_read = (x.reg_dst || x.mem_write);
      if (!(m.valid && m.mem_read && m.write_reg != 0 && x.valid)) return 0;
      return (m.write_reg == x.rs) || (rt_read && m.write_reg == x.rt);
   endfunction

   function automatic ex_t capture(input id_t x);
      ex_t e = '0;
      e.valid = x.valid;
      if (x.valid) begin
         e.reg_write = x.reg_write; e.alu_src = x.alu_src; e.alu_op = x.alu_op;
         e.mem_read = x.mem_read; e.mem_write = x.mem_write;
         e.mem_to_reg = x.mem_to_reg; e.branch = x.branch;
      end
      e.pc4 = x.pc4; e.rs_data = x.rs_data; e.rt_data = x.rt_data;
      e.imm_sext = 32'($signed(x.imm));
      e.rs = x.rs; e.rt = x.rt;
      e.write_reg = (x.valid && x.reg_dst) ? x.rd : x.rt;
      return e;
   endfunction

   // One pipeline cycle: drive at negedge, sample stall, clock, advance model.
   task automatic cycle(input id_t x, input logic f, output logic obs_st, output logic exp_st);
      bit hz;
      @(negedge clk);
      idv = x; fl = f;
      #1;
      obs_st = stall;
      hz = model_hazard(x);
      exp_st = hz && !f;
      @(posedge clk);
      if (f) begin
         m = '0; if (fcnt < SAT) fcnt++;
      end else if (hz) begin
         m = '0; if (bcnt < SAT) bcnt++;
      end else begin
         m = capture(x);
      end
      #1;
   endtask

   task automatic test_reset();
      logic os, es;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idv = id_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         fl = 1'($urandom);
         #1;
         cmp++;
         if (dut_bus !== '0 || stall !== 1'b0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
            err++;
            $display("FAIL reset_state: bus=%h stall=%b bc=%0d fc=%0d required all zero",
                     dut_bus, stall, bubble_cnt, flush_cnt);
         end
      end
      m = '0; bcnt = 0; fcnt = 0;
      @(negedge clk);
      fl = 1'b0;
      rst_n = 1'b1;
      cycle(mk(KIND_R, 1, 2, 3), 1'b0, os, es);
      cmp++;
      if (ex_write_reg !== 5'd3 || ex_alu_op !== 2'b00 || ex_reg_write !== 1'b1 ||
          ex_valid !== 1'b1) begin
         err++;
         $display("FAIL reset_release_add: wr=%0d op=%b rw=%b v=%b required wr=3 op=00 rw=1 v=1",
                  ex_write_reg, ex_alu_op, ex_reg_write, ex_valid);
      end
      cmp++;
      if (ex_mask(dut_bus) !== ex_mask(m)) begin
         err++;
         $display("FAIL reset_release_bus: got %h required %h", ex_mask(dut_bus), ex_mask(m));
      end
   endtask

   task automatic test_load_use();
      logic os, es;
      id_t add5 = mk(KIND_R, 5, 9, 10);
      cycle(mk(KIND_LW, 4, 5, 0), 1'b0, os, es);
      cycle(add5, 1'b0, os, es);
      cmp++;
      if (os !== 1'b1) begin
         err++; $display("FAIL load_use_stall: stall=%b required 1", os);
      end
      cmp++;
      if (ex_valid !== 1'b0 || bubble_cnt !== 8'd1 || ex_mask(dut_bus) !== '0) begin
         err++;
         $display("FAIL load_use_bubble: v=%b bc=%0d bus=%h required v=0 bc=1 bus=0",
                  ex_valid, bubble_cnt, dut_bus);
      end
      cycle(add5, 1'b0, os, es);
      cmp++;
      if (os !== 1'b0 || ex_mask(dut_bus) !== ex_mask(m) || ex_valid !== 1'b1) begin
         err++;
         $display("FAIL load_use_recapture: stall=%b bus=%h required stall=0 bus=%h",
                  os, dut_bus, m);
      end
   endtask

   task automatic test_no_false_hazard();
      logic os, es;
      cycle(mk(KIND_LW, 3, 0, 0), 1'b0, os, es);
      cycle(mk(KIND_R, 0, 0, 7), 1'b0, os, es);
      cmp++;
      if (os !== 1'b0) begin
         err++; $display("FAIL load_r0_stall: stall=%b required 0", os);
      end
      cycle(mk(KIND_LW, 3, 5, 0), 1'b0, os, es);
      cycle(mk(KIND_JZ, 6, 5, 0), 1'b0, os, es);
      cmp++;
      if (os !== 1'b0 || ex_valid !== 1'b1) begin
         err++; $display("FAIL jz_rt_field_stall: stall=%b v=%b required stall=0 v=1", os, ex_valid);
      end
      cycle(mk(KIND_LW, 3, 8, 0), 1'b0, os, es);
      cycle(mk(KIND_SW, 2, 8, 0), 1'b0, os, es);
      cmp++;
      if (os !== 1'b1) begin
         err++; $display("FAIL sw_rt_hazard: stall=%b required 1", os);
      end
   endtask

   task automatic test_flush_hazard();
      logic os, es;
      int bc0 = bcnt;
      int fc0 = fcnt;
      cycle(mk(KIND_LW, 1, 7, 0), 1'b0, os, es);
      cycle(mk(KIND_R, 7, 2, 4), 1'b1, os, es);
      cmp++;
      if (os !== 1'b0) begin
         err++; $display("FAIL flush_masks_stall: stall=%b required 0", os);
      end
      cmp++;
      if (ex_valid !== 1'b0 || int'(flush_cnt) !== fc0 + 1 || int'(bubble_cnt) !== bc0) begin
         err++;
         $display("FAIL flush_counts: v=%b fc=%0d bc=%0d required v=0 fc=%0d bc=%0d",
                  ex_valid, flush_cnt, bubble_cnt, fc0 + 1, bc0);
      end
   endtask

   task automatic test_sign_ext();
      logic os, es;
      id_t x = mk(KIND_SW, 9, 10, 0);
      x.imm = 16'h8004;
      cycle(x, 1'b0, os, es);
      cmp++;
      if (ex_imm_sext !== 32'hFFFF8004) begin
         err++; $display("FAIL sext_neg: got %h required ffff8004", ex_imm_sext);
      end
      x.imm = 16'h7FFF;
      cycle(x, 1'b0, os, es);
      cmp++;
      if (ex_imm_sext !== 32'h00007FFF) begin
         err++; $display("FAIL sext_pos: got %h required 00007fff", ex_imm_sext);
      end
   endtask

   task automatic test_random();
      logic os, es;
      id_t  x;
      for (int i = 0; i < 400; i++) begin
         x = mk(int'($urandom_range(3)), int'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(3)));
         if ($urandom_range(7) == 0) x.valid = 1'b0;
         cycle(x, ($urandom_range(7) == 0), os, es);
         cmp++;
         if (os !== es) begin
            err++; $display("FAIL rand_stall[%0d]: got %b required %b", i, os, es);
         end
         cmp++;
         if (ex_mask(dut_bus) !== ex_mask(m)) begin
            err++; $display("FAIL rand_bus[%0d]: got %h required %h", i, ex_mask(dut_bus), ex_mask(m));
         end
         cmp++;
         if (int'(bubble_cnt) !== bcnt || int'(flush_cnt) !== fcnt) begin
            err++;
            $display("FAIL rand_cnt[%0d]: bc=%0d fc=%0d required bc=%0d fc=%0d",
                     i, bubble_cnt, flush_cnt, bcnt, fcnt);
         end
      end
   endtask

   task automatic test_saturation();
      logic os, es;
      for (int i = 0; i < SAT + 4; i++) begin
         cycle(mk(KIND_LW, 2, 1, 0), 1'b0, os, es);
         cycle(mk(KIND_R, 1, 3, 4), 1'b0, os, es);
      end
      cmp++;
      if (int'(bubble_cnt) !== SAT || bcnt != SAT) begin
         err++; $display("FAIL bubble_saturate: got %0d required %0d", bubble_cnt, SAT);
      end
      for (int i = 0; i < SAT + 4; i++) cycle(mk(KIND_R, 1, 2, 3), 1'b1, os, es);
      cmp++;
      if (int'(flush_cnt) !== SAT || int'(bubble_cnt) !== SAT) begin
         err++;
         $display("FAIL flush_saturate: fc=%0d bc=%0d required both %0d", flush_cnt, bubble_cnt, SAT);
      end
   endtask

   task automatic test_async_reset();
      logic os, es;
      cycle(mk(KIND_LW, 2, 5, 0), 1'b0, os, es);
      @(negedge clk);
      idv = mk(KIND_R, 5, 6, 7);
      #1;
      cmp++;
      if (stall !== 1'b1) begin
         err++; $display("FAIL async_pre_stall: stall=%b required 1", stall);
      end
      #1;
      rst_n = 1'b0;
      #1;
      cmp++;
      if (stall !== 1'b0 || dut_bus !== '0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
         err++;
         $display("FAIL async_reset_clear: stall=%b bus=%h bc=%0d fc=%0d required all zero",
                  stall, dut_bus, bubble_cnt, flush_cnt);
      end
      m = '0; bcnt = 0; fcnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(mk(KIND_R, 5, 6, 7), 1'b0, os, es);
      cmp++;
      if (os !== 1'b0 || ex_mask(dut_bus) !== ex_mask(m)) begin
         err++; $display("FAIL async_resume: stall=%b bus=%h required stall=0 bus=%h", os, dut_bus, m);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_flush_hazard();
      test_sign_ext();
      test_random();
      test_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS pipeline. It sits directly downstream of the instruction-decode control unit and captures that unit's control outputs, register-file read data, sign-extended immediate and register specifiers for the EX stage. It also contains load-use hazard detection: it raises a stall to the PC and IF/ID registers and inserts a bubble into EX. It accepts a flush from branch resolution and keeps saturating bubble and flush counters for debug.

Parameters:
DW, 32, datapath width (register data, PC).
CNT_W, 16, width of bubble and flush counters.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_reg_dst  in  1  decoder RegDst
id_reg_write  in  1  decoder RegWrite
id_alu_src  in  1  decoder ALUSrc
id_alu_op  in  2  decoder ALUop: R=00, JZ=01, SW=10, LW=11
id_mem_read  in  1  decoder MemRead
id_mem_write  in  1  decoder MemWrite
id_mem_to_reg  in  1  decoder MemtoReg
id_branch  in  1  decoder Branch
id_pc4  in  DW  PC+4 of ID instruction
id_rs_data  in  DW  register file port A
id_rt_data  in  DW  register file port B
id_rs, id_rt, id_rd  in  5 each  instruction fields [25:21], [20:16], [15:11]
id_imm  in  16  instruction [15:0]
flush  in  1  branch taken: squash ID instruction
ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered controls
ex_alu_op  out  2  registered ALUop
ex_pc4, ex_rs_data, ex_rt_data, ex_imm_sext  out  DW each  registered data; imm sign-extended
ex_rs, ex_rt  out  5 each  registered specifiers (for forwarding)
ex_write_reg  out  5  ex_reg_dst ? rd : rt, resolved at capture
stall  out  1  combinational: hold PC and IF/ID this cycle
bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including both counters. stall is 0 because ex_mem_read is 0.
- hazard = ex_valid & ex_mem_read & (ex_write_reg != 0) & id_valid & ((ex_write_reg == id_rs) | ((id_reg_dst | id_mem_write) & ex_write_reg == id_rt)).
- stall = hazard & ~flush. Flush overrides, because the ID instruction is squashed anyway.
- Per-edge priority: flush > hazard > normal capture.
- flush: load a bubble. ex_valid and all control bits are 0, alu_op = 00, data and specifier fields are 0. flush_cnt increments.
- hazard (and no flush): same bubble load. bubble_cnt increments. The ID instruction is held upstream and re-presented next cycle.
- Normal: capture all inputs. ex_valid = id_valid. If id_valid = 0, control bits are captured as 0 regardless of the decoder outputs.
- ex_imm_sext = {(DW-16){id_imm[15]}, id_imm}.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs. There is no internal stall holding: EX is never frozen.
- Counters saturate at all-ones and never wrap. A single edge increments at most one counter.
- A load into $0 (ex_write_reg = 0) never stalls.
- Back-to-back: after one bubble, ex_mem_read = 0, so stall drops and the held instruction captures normally. Max stall per load-use is exactly 1 cycle.
- Reset asserted mid-stall clears ex state immediately. stall falls combinationally in the same cycle.

Test Plan:
- Reset: rst_n = 0 with random inputs -> all ex_* = 0, stall = 0, counters = 0. Release with an R-type add (rs=1, rt=2, rd=3) -> next edge ex_write_reg = 3, ex_alu_op = 00, ex_reg_write = 1.
- Load-use: LW rt=5 in EX, then add rs=5 in ID -> stall = 1 for one cycle, EX gets a bubble (ex_valid = 0), bubble_cnt = 1. The following edge captures the add; stall = 0.
- No false hazard: LW into $0 followed by use of $0 -> stall = 0. Also LW rt=5, then JZ rs=6 with rt field=5 (RegDst = 0, MemWrite = 0) -> stall = 0.
- Flush during hazard: load-use condition plus flush = 1 -> stall = 0, bubble loaded, flush_cnt = 1, bubble_cnt unchanged.
- Sign extension: id_imm = 16'h8004 -> ex_imm_sext = 32'hFFFF8004. id_imm = 16'h7FFF -> 32'h00007FFF.
- Saturation: force 65 536+ consecutive hazards -> bubble_cnt holds at 16'hFFFF. Asynchronous reset between edges -> outputs clear without waiting for a clock edge.
